// File: rtl/titan_lsu_if.sv
// Signal bundle between the EX stage, the titan_lsu load/store unit and the data bus.
// The slave modport is the LSU side. The master modport is the pipeline/bus side.
interface titan_lsu_if;
  logic        req_valid;
  logic [5:0]  mem_flags;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_sel;
  logic        dmem_we;
  logic        dmem_cyc;
  logic        dmem_ack;
  logic        dmem_err;
  logic [31:0] dmem_rdata;
  logic [31:0] load_data;
  logic        done;
  logic        stall;
  logic [1:0]  exc;

  modport slave (
    input  req_valid, mem_flags, addr, wdata, dmem_ack, dmem_err, dmem_rdata,
    output dmem_addr, dmem_wdata, dmem_sel, dmem_we, dmem_cyc, load_data, done, stall, exc
  );

  modport master (
    output req_valid, mem_flags, addr, wdata, dmem_ack, dmem_err, dmem_rdata,
    input  dmem_addr, dmem_wdata, dmem_sel, dmem_we, dmem_cyc, load_data, done, stall, exc
  );
endinterface

// File: rtl/titan_lsu.sv
// Single-outstanding load/store unit: lane steering, bus handshake and load extension.
// Optional misalignment trapping is enabled by defining TITAN_LSU_MISALIGN_EN.
module titan_lsu (
  input  logic       clk,
  input  logic       rst_n,
  titan_lsu_if.slave lsu
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_BUS      = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  exc_q;
  logic [1:0]  lane_q;
  logic        hw_q, byte_q, uns_q;
  logic [31:0] addr_q, wdata_q, load_q;
  logic [3:0]  sel_q;
  logic        we_q, cyc_q;

  logic        req_wr, req_rd, req_word, req_hw, req_byte;
  logic        op_req, illegal, misalign;
  logic [3:0]  sel_d;
  logic [31:0] wdata_d, load_d, rdata_shifted;
  logic [4:0]  rd_shamt;
  logic        stall, done;
  logic [1:0]  exc;

  assign req_wr   = lsu.mem_flags[5];
  assign req_rd   = lsu.mem_flags[4];
  assign req_word = lsu.mem_flags[3];
  assign req_hw   = lsu.mem_flags[2];
  assign req_byte = lsu.mem_flags[1];

  assign op_req  = lsu.req_valid & (req_wr | req_rd);
  assign illegal = ~(req_wr ^ req_rd) | ~$onehot({req_word, req_hw, req_byte});

`ifdef TITAN_LSU_MISALIGN_EN
  assign misalign = (req_hw & lsu.addr[0]) | (req_word & (lsu.addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Store lane steering, computed from the live request and latched on accept
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sel_d   = 4'b1111;
    wdata_d = lsu.wdata;
    if (req_byte) begin
      sel_d   = 4'b0001 << lsu.addr[1:0];
      wdata_d = {4{lsu.wdata[7:0]}};
    end else if (req_hw) begin
      sel_d   = lsu.addr[1] ? 4'b1100 : 4'b0011;
      wdata_d = {2{lsu.wdata[15:0]}};
    end
  end

  // Load extraction uses the lane and size latched at accept time
  always_comb begin
    rd_shamt = 5'd0;
    if (byte_q)    rd_shamt = {lane_q, 3'b000};
    else if (hw_q) rd_shamt = {lane_q[1], 4'b0000};
    rdata_shifted = lsu.dmem_rdata >> rd_shamt;
    load_d        = rdata_shifted;
    if (byte_q)
      load_d = uns_q ? {24'b0, rdata_shifted[7:0]} : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
    else if (hw_q)
      load_d = uns_q ? {16'b0, rdata_shifted[15:0]} : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (op_req) state_d = (illegal || misalign) ? RESP : BUSY;
      BUSY:    if (lsu.dmem_ack || lsu.dmem_err) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    done  = 1'b0;
    exc   = EXC_NONE;
    case (state_q)
      IDLE:    stall = op_req;
      BUSY:    stall = 1'b1;
      RESP: begin
        done = 1'b1;
        exc  = exc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_q   <= EXC_NONE;
      lane_q  <= 2'b00;
      hw_q    <= 1'b0;
      byte_q  <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      sel_q   <= 4'b0000;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (op_req) begin
          load_q <= '0;
          if (illegal) begin
            exc_q <= EXC_ILLEGAL;
          end else if (misalign) begin
            exc_q <= EXC_MISALIGN;
          end else begin
            exc_q   <= EXC_NONE;
            lane_q  <= lsu.addr[1:0];
            hw_q    <= req_hw;
            byte_q  <= req_byte;
            uns_q   <= lsu.mem_flags[0];
            addr_q  <= {lsu.addr[31:2], 2'b00};
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            we_q    <= req_wr;
            cyc_q   <= 1'b1;
          end
        end
        // Error wins over a simultaneous ack
        BUSY: if (lsu.dmem_err) begin
          cyc_q  <= 1'b0;
          exc_q  <= EXC_BUS;
          load_q <= '0;
        end else if (lsu.dmem_ack) begin
          cyc_q  <= 1'b0;
          load_q <= we_q ? 32'b0 : load_d;
        end
        default: ;
      endcase
    end
  end

  assign lsu.dmem_addr  = addr_q;
  assign lsu.dmem_wdata = wdata_q;
  assign lsu.dmem_sel   = sel_q;
  assign lsu.dmem_we    = we_q;
  assign lsu.dmem_cyc   = cyc_q;
  assign lsu.load_data  = load_q;
  assign lsu.done       = done;
  assign lsu.stall      = stall;
  assign lsu.exc        = exc;
endmodule
